// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider FSM encoding and divide-by-zero quotient.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

  localparam logic [ALU_WIDTH-1:0] DIVZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/alu_divider_seq_if.sv
// Start/Done handshake bundle between the ALU control FSM (master) and the divider (slave).
// The sign select exists only when ALU_DIV_SIGNED_EN is defined.
interface alu_divider_seq_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ALU_DIV_SIGNED_EN
  logic             sign;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             z;
  logic             divz;

`ifdef ALU_DIV_SIGNED_EN
  modport master (output start, a, b, sign, input busy, done, q, r, z, divz);
  modport slave  (input start, a, b, sign, output busy, done, q, r, z, divz);
`else
  modport master (output start, a, b, input busy, done, q, r, z, divz);
  modport slave  (input start, a, b, output busy, done, q, r, z, divz);
`endif

endinterface

// File: rtl/div_sub_stage.sv
// One restoring-division step: shift the next dividend bit into the remainder and trial-subtract.
module div_sub_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor keeps shifted below 2*divisor, so WIDTH+1 bits hold the sign of diff.
  assign shifted = {rem_i, quo_msb_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign qbit_o  = ~diff[WIDTH];
  assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_divider_seq.sv
// Multi-cycle shift-subtract divider, one trial subtraction per clock, Start/Done handshake.
// Define ALU_DIV_SIGNED_EN to add signed division via the interface sign select.
module alu_divider_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input logic              clk,
  input logic              rst_n,
  alu_divider_seq_if.slave dif
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             z_q, z_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] stage_rem;
  logic             stage_qbit;

`ifdef ALU_DIV_SIGNED_EN
  assign a_neg = dif.sign & dif.a[WIDTH-1];
  assign b_neg = dif.sign & dif.b[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  assign a_mag = a_neg ? -dif.a : dif.a;
  assign b_mag = b_neg ? -dif.b : dif.b;

  div_sub_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .rem_i    (rem_q),
    .quo_msb_i(quo_q[WIDTH-1]),
    .divisor_i(b_q),
    .rem_o    (stage_rem),
    .qbit_o   (stage_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    a_d     = a_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    q_d     = q_q;
    r_d     = r_q;
    z_d     = z_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (dif.start) begin
          a_d     = dif.a;
          b_d     = b_mag;
          quo_d   = a_mag;
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          state_d = (dif.b == '0) ? DIV_FIN : DIV_RUN;
        end
      end
      DIV_RUN: begin
        rem_d = stage_rem;
        quo_d = {quo_q[WIDTH-2:0], stage_qbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DIV_FIN;
      end
      DIV_FIN: begin
        done_d  = 1'b1;
        state_d = DIV_IDLE;
        divz_d  = (b_q == '0);
        if (divz_d) begin
          q_d = WIDTH'(DIVZ_QUOTIENT);
          r_d = a_q;
        end else begin
          q_d = q_neg_q ? -quo_q : quo_q;
          r_d = r_neg_q ? -rem_q : rem_q;
        end
        z_d = (q_d == '0);
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      a_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      z_q     <= 1'b1;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      a_q     <= a_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      z_q     <= z_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end

  assign dif.busy = (state_q == DIV_RUN);
  assign dif.done = done_q;
  assign dif.q    = q_q;
  assign dif.r    = r_q;
  assign dif.z    = z_q;
  assign dif.divz = divz_q;

endmodule

// File: tb/tb_alu_divider_seq.sv
// Directed bench for alu_divider_seq: vector table plus ignored-start and reset-abort sequences.
module tb_alu_divider_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_divider_seq_if #(.WIDTH(32)) dif ();

  alu_divider_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dif  (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        divz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation; optionally re-pulse start (A=9,B=3) at cycle 'inject' to test ignoring.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input int inject, output int lat, output int busy_cnt);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
`ifdef ALU_DIV_SIGNED_EN
    dif.sign  = sgn;
`endif
    lat      = -1;
    busy_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        dif.start = 1'b0;
        dif.a     = ~a;
        dif.b     = b + 32'd1;
      end
      if (c == inject) begin
        dif.start = 1'b1;
        dif.a     = 32'd9;
        dif.b     = 32'd3;
      end
      if (c == inject + 1) dif.start = 1'b0;
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        lat = c;
        break;
      end
    end
    dif.start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input int busy_cnt);
    check({tag, " latency"}, lat, (v.b == 32'd0) ? 34'd2 : 34'd34);
    check({tag, " busy_cycles"}, busy_cnt, (v.b == 32'd0) ? 0 : 32);
    check({tag, " q"}, dif.q, v.q);
    check({tag, " r"}, dif.r, v.r);
    check({tag, " z"}, dif.z, v.z);
    check({tag, " divz"}, dif.divz, v.divz);
    @(negedge clk);
    check({tag, " done_pulse_end"}, dif.done, 1'b0);
    check({tag, " q_held"}, dif.q, v.q);
    check({tag, " r_held"}, dif.r, v.r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_cnt;
    int dones;
    vec_t v;
    n_checks = 0;
    n_fail   = 0;

    vecs.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0});
    vecs.push_back('{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b1, 1'b0});
    vecs.push_back('{32'd123, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd123, 1'b0, 1'b1});
    vecs.push_back('{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA, 32'd2, 1'b0, 1'b0});
    vecs.push_back('{32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 1'b0});
    vecs.push_back('{32'd12345678, 32'd1000, 1'b0, 32'd12345, 32'd678, 1'b0, 1'b0});
`ifdef ALU_DIV_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0});
    vecs.push_back('{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b1});
`endif

    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
`ifdef ALU_DIV_SIGNED_EN
    dif.sign  = 1'b0;
`endif
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", dif.busy, 1'b0);
    check("reset done", dif.done, 1'b0);
    check("reset q", dif.q, 32'd0);
    check("reset r", dif.r, 32'd0);
    check("reset z", dif.z, 1'b1);
    check("reset divz", dif.divz, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, -10, lat, busy_cnt);
      check_result($sformatf("vec%0d", i), vecs[i], lat, busy_cnt);
    end

    // Start pulsed mid-run must be ignored.
    v = '{32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0};
    do_op(v.a, v.b, v.sgn, 10, lat, busy_cnt);
    check_result("ignored_start", v, lat, busy_cnt);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done) dones++;
    end
    check("ignored_start no_extra_done", dones, 0);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    dif.start = 1'b1;
    dif.a     = 32'd1000;
    dif.b     = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort busy_before", dif.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort busy", dif.busy, 1'b0);
    check("abort q", dif.q, 32'd0);
    check("abort r", dif.r, 32'd0);
    check("abort z", dif.z, 1'b1);
    check("abort divz", dif.divz, 1'b0);
    dones = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (dif.done || dif.busy) dones++;
    end
    check("abort no_done", dones, 0);
    v = '{32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 1'b0};
    do_op(v.a, v.b, v.sgn, -10, lat, busy_cnt);
    check_result("after_reset", v, lat, busy_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
